// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  localparam int DIV_ITER = 32;
  localparam logic [DIV_ITER-1:0] DIVZERO_LO = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left and conditionally subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // Shifted remainder needs one extra bit; it can reach 2*divisor-1.
  logic [WIDTH:0] shifted;
  logic           ge;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    ge       = (shifted >= {1'b0, divisor});
    rem_next = ge ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage DIV/DIVU controller: operand capture, iteration control, sign fixup, stall/ready.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             sa, sb;
  logic [WIDTH-1:0] opa_mag, opb_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Handshake: start is taken only in IDLE without cancel; ready pulses exactly
  // one cycle (the DONE cycle) with hi/lo already valid; stall holds EX from
  // the accepting cycle through the last iteration and drops in DONE.
  always_comb begin
    sa        = signed_div & opa[WIDTH-1];
    sb        = signed_div & opb[WIDTH-1];
    opa_mag   = sa ? -opa : opa;
    opb_mag   = sb ? -opb : opb;
    stall     = ((state == S_IDLE) & start & ~cancel) | (state == S_BUSY);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      ready   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            divisor <= opb_mag;
            quo     <= opa_mag;
            rem     <= '0;
            count   <= '0;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            if (opb == '0) begin
              // Divide by zero is defined: no iterations, no sign fixup.
              hi    <= opa;
              lo    <= DIVZERO_LO;
              ready <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            rem   <= step_rem;
            quo   <= step_quo;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              lo    <= neg_q ? -step_quo : step_quo;
              hi    <= neg_r ? -step_rem : step_rem;
              ready <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: results, latency, stall window, cancel, reset.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, cancel;
  logic [31:0] opa, opb;
  logic        stall, ready;
  logic [31:0] hi, lo;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .cancel     (cancel),
    .stall      (stall),
    .ready      (ready),
    .hi         (hi),
    .lo         (lo),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide and measure it. lat = cycles from the start cycle to ready
  // (-1 on timeout); stalls = cycles with stall high up to ready.
  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stalls,
                        output logic [31:0] lo_o, output logic [31:0] hi_o,
                        output logic stall_at_ready, output logic ready_after);
    int n;
    next_cycle();
    start = 1'b1; signed_div = sd; opa = a; opb = b;
    #1;
    stalls = (stall === 1'b1) ? 1 : 0;
    next_cycle();
    start = 1'b0;
    n = 1;
    while (ready !== 1'b1 && n <= 60) begin
      if (stall === 1'b1) stalls++;
      next_cycle();
      n++;
    end
    lat = (n > 60) ? -1 : n;
    lo_o = lo; hi_o = hi; stall_at_ready = stall;
    next_cycle();
    ready_after = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; opa = '0; opb = '0;
    next_cycle();
    next_cycle();
    total++; if ({stall, ready} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {stall, ready}); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo got hi=%h lo=%h exp 0", hi, lo); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    rst = 1'b0;
  endtask

  task automatic test_results();
    // {signed, a, b, exp_lo, exp_hi, exp_latency}
    logic [31:0] va [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFFB};
    logic [31:0] vb [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic        vs [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] el [7] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] eh [7] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h80000000, 32'd5, 32'hFFFFFFFB};
    int          elat [7] = '{33, 33, 33, 33, 33, 1, 1};
    int lat, stalls;
    logic [31:0] lo_o, hi_o;
    logic s_rdy, r_aft;
    for (int i = 0; i < 7; i++) begin
      do_div(vs[i], va[i], vb[i], lat, stalls, lo_o, hi_o, s_rdy, r_aft);
      total++; if (lat != elat[i]) begin bad++; $display("FAIL latency_%0d got=%0d exp=%0d", i, lat, elat[i]); end
      total++; if (lo_o !== el[i]) begin bad++; $display("FAIL lo_%0d got=%h exp=%h", i, lo_o, el[i]); end
      total++; if (hi_o !== eh[i]) begin bad++; $display("FAIL hi_%0d got=%h exp=%h", i, hi_o, eh[i]); end
      total++; if (stalls != elat[i]) begin bad++; $display("FAIL stall_cycles_%0d got=%0d exp=%0d", i, stalls, elat[i]); end
      total++; if (s_rdy !== 1'b0) begin bad++; $display("FAIL stall_at_ready_%0d got=%b exp=0", i, s_rdy); end
      total++; if (r_aft !== 1'b0) begin bad++; $display("FAIL ready_pulse_%0d got=%b exp=0", i, r_aft); end
    end
  endtask

  task automatic test_cancel();
    int lat, stalls, seen;
    logic [31:0] lo_o, hi_o;
    logic s_rdy, r_aft;
    // start & cancel together in IDLE: nothing accepted
    next_cycle();
    start = 1'b1; cancel = 1'b1; signed_div = 1'b0; opa = 32'd50; opb = 32'd3;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL start_cancel_stall got=%b exp=0", stall); end
    next_cycle();
    start = 1'b0; cancel = 1'b0;
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL start_cancel_state got=%0d exp=0", state_dbg); end
    // start at T, cancel at T+10; prior result is -5/0 (lo=FFFFFFFF, hi=FFFFFFFB)
    start = 1'b1; opa = 32'd100; opb = 32'd7;
    next_cycle();
    start = 1'b0;
    for (int i = 1; i < 10; i++) next_cycle();
    cancel = 1'b1;
    next_cycle();
    cancel = 1'b0;
    total++; if (state_dbg !== 2'd0 || stall !== 1'b0) begin bad++; $display("FAIL cancel_idle got state=%0d stall=%b exp 0/0", state_dbg, stall); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (ready === 1'b1) seen++;
      next_cycle();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL cancel_no_ready got=%0d exp=0", seen); end
    total++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFFB) begin bad++; $display("FAIL cancel_hold got lo=%h hi=%h exp lo=ffffffff hi=fffffffb", lo, hi); end
    do_div(1'b0, 32'd1000, 32'd33, lat, stalls, lo_o, hi_o, s_rdy, r_aft);
    total++; if (lat != 33 || lo_o !== 32'd30 || hi_o !== 32'd10) begin bad++; $display("FAIL after_cancel got lat=%0d lo=%0d hi=%0d exp 33/30/10", lat, lo_o, hi_o); end
  endtask

  task automatic test_back_to_back();
    int n, readies;
    logic [31:0] lo_c, hi_c;
    // second start during BUSY is ignored; original operands complete
    next_cycle();
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    next_cycle();
    start = 1'b0;
    n = 1; readies = 0; lo_c = '0; hi_c = '0;
    while (n <= 40) begin
      if (n == 5) begin start = 1'b1; opa = 32'd9; opb = 32'd0; end
      if (n == 6) start = 1'b0;
      #1;
      if (ready === 1'b1) begin
        readies++;
        if (readies == 1) begin lo_c = lo; hi_c = hi; end
        total++; if (n != 33) begin bad++; $display("FAIL busy_start_latency got=%0d exp=33", n); end
      end
      next_cycle();
      n++;
    end
    total++; if (readies != 1) begin bad++; $display("FAIL busy_start_readies got=%0d exp=1", readies); end
    total++; if (lo_c !== 32'd14 || hi_c !== 32'd2) begin bad++; $display("FAIL busy_start_result got lo=%0d hi=%0d exp 14/2", lo_c, hi_c); end
    // reset at T+20 mid-operation
    start = 1'b1; opa = 32'd77; opb = 32'd5;
    next_cycle();
    start = 1'b0;
    for (int i = 1; i < 20; i++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    total++; if ({stall, ready, state_dbg} !== 4'b0000 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL mid_reset got stall=%b ready=%b state=%0d hi=%h lo=%h exp all 0", stall, ready, state_dbg, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_results();
    test_cancel();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
